cla_serial_add_ctrl: RTL and testbench

//   Sequencer that adds two WORDS*4-bit operands on one 4-bit CLA_Adder.
//   The adder instance is inside this block. The sequencer feeds it one
//   4-bit slice per cycle, least significant slice first, and carries Cout

---
 rtl/cla_serial_add_ctrl.sv | 143 ++++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cla_serial_add_ctrl.sv
// Serial wide adder: one 4-bit CLA slice per cycle, LSB slice first.
// Operands and results move through valid/ready handshakes.
module CLA_Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];
endmodule

module cla_serial_add_ctrl #(
  parameter  int WORDS = 4,
  localparam int W     = 4 * WORDS,
  localparam int CW    = $clog2(WORDS + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] sum_out,
  output logic         cout_out,
  output logic         busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    s4;
  logic          co;
  logic [W-1:0]  acc_nx;

  CLA_Adder u_cla (
    .A    (a_sh_q[3:0]),
    .B    (b_sh_q[3:0]),
    .Cin  (carry_q),
    .Sum  (s4),
    .Cout (co)
  );

  // New slice enters at the top; after WORDS shifts acc is aligned.
  assign acc_nx = (acc_q >> 4) | (W'(s4) << (W - 4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = RUN;
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        acc_d   = acc_nx;
        carry_d = co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WORDS - 1)) begin
          state_d = DONE;
          sum_d   = acc_nx;
          cout_d  = co;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl at WORDS=4 and WORDS=1.
// Drives and samples #1 after each rising edge.
module tb_cla_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        sv4 = 1'b0, rr4 = 1'b1, c4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        sr4, rv4, co4, bz4;
  logic [15:0] s4;

  logic        sv1 = 1'b0, rr1 = 1'b1, c1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        sr1, rv1, co1, bz1;
  logic [3:0]  s1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cla_serial_add_ctrl #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv4), .start_ready(sr4),
    .a_in(a4), .b_in(b4), .cin(c4),
    .res_valid(rv4), .res_ready(rr4),
    .sum_out(s4), .cout_out(co4), .busy(bz4)
  );

  cla_serial_add_ctrl #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .cin(c1),
    .res_valid(rv1), .res_ready(rr1),
    .sum_out(s1), .cout_out(co1), .busy(bz1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, count edges to res_valid, check result.
  task automatic op4(input string tag,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic c,
                     input logic [15:0] es, input logic ec);
    int n;
    a4 = a; b4 = b; c4 = c; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    a4 = ~a; b4 = ~b; c4 = ~c;
    n = 0;
    while (!rv4 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(s4), 32'(es));
    chk({tag, "_cout"}, 32'(co4), 32'(ec));
    if (rr4) begin
      tick();
      chk({tag, "_idle"}, 32'(sr4), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] held;
    logic [4:0]  exp5;
    int          n;

    #2;
    chk("rst_sr", 32'(sr4), 32'd1);
    chk("rst_rv", 32'(rv4), 32'd0);
    chk("rst_busy", 32'(bz4), 32'd0);
    chk("rst_sum", 32'(s4), 32'd0);
    chk("rst_cout", 32'(co4), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    op4("t1", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    op4("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    op4("t3a", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    op4("t3b", 16'hBC00, 16'h7800, 1'b0, 16'h3400, 1'b1);

    rr4 = 1'b0;
    op4("t4", 16'h1357, 16'h2468, 1'b0, 16'h37BF, 1'b0);
    held = s4;
    for (int i = 0; i < 3; i++) begin
      a4 = 16'h1111; b4 = 16'h2222; c4 = 1'b1; sv4 = 1'b1;
      tick();
      chk("t4_rv", 32'(rv4), 32'd1);
      chk("t4_sum", 32'(s4), 32'(held));
      chk("t4_sr", 32'(sr4), 32'd0);
      chk("t4_busy", 32'(bz4), 32'd1);
    end
    sv4 = 1'b0;
    rr4 = 1'b1;
    tick();
    chk("t4_rel", 32'(rv4), 32'd0);
    chk("t4_keep", 32'(s4), 32'h37BF);
    chk("t4_noacc", 32'(bz4), 32'd0);

    a4 = 16'h1111; b4 = 16'h2222; c4 = 1'b0; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_sr", 32'(sr4), 32'd1);
    chk("t5_rv", 32'(rv4), 32'd0);
    chk("t5_busy", 32'(bz4), 32'd0);
    chk("t5_sum", 32'(s4), 32'd0);
    chk("t5_cout", 32'(co4), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rv4) n++;
    end
    chk("t5_norv", 32'(n), 32'd0);
    op4("t5n", 16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1);

    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      v = 9'(k);
      a1 = v[3:0]; b1 = v[7:4]; c1 = v[8]; sv1 = 1'b1;
      exp5 = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      tick();
      sv1 = 1'b0;
      a1 = ~a1; b1 = ~b1;
      n = 0;
      while (!rv1 && n < 10) begin
        tick();
        n++;
      end
      chk("t6_lat", 32'(n), 32'd1);
      chk("t6_res", 32'({co1, s1}), 32'(exp5));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
